sdcm_block_reader: RTL and testbench
====================================

# sdcm_block_reader

Hardware sequencer that drives the SD-card port register interface (the 1-bit-address, write-strobe, 8-bit-data bus otherwise driven by the PicoBlaze) to fetch one complete card block without CPU involvement. It performs the address-load/read-block/next-byte command sequence, polls the status register, and streams the block out as a valid/ready byte stream. It sits between a block-request client (loader or DMA) and the SD-card port.

## Interface
- `BLOCK_BYTES`, 512: bytes streamed per block.
- `SETTLE_CYC`, 4: idle cycles after each 0x02/0x04 command write before status polling starts (minimum 1).
- `TO_W`, 24: timeout counter width; polling aborts after 2^TO_W−1 cycles without ready.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request one block read; sampled only while `busy`=0.
- `block_addr` in 32: card block address, latched on accepted `start`.
- `busy` out 1: high from the cycle after accepted `start` until `done`/`error` cycle inclusive.
- `done` out 1: 1-cycle pulse after the last byte handshake.
- `error` out 1: 1-cycle pulse on abort; `err_code` valid the same cycle and held until next `start`.
- `err_code` out 2: 01 = port reported sdhost_err, 10 = poll timeout, 00 = none.
- `out_data` out 8, `out_valid` out 1, `out_ready` in 1, `out_last` out 1: byte stream; `out_last` qualifies byte BLOCK_BYTES−1.
- `port_en` out 1, `port_addr` out 1, `port_wr` out 1, `port_wdata` out 8: to port enable/addr/w_strobe/din.
- `port_rdata` in 8: from port dout (combinational, valid while `port_en`=1 and `port_wr`=0).

## Operation
- Reset values: all outputs 0, `err_code`=00, FSM in IDLE, counters 0.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, SETTLE, POLL, READ, PUSH, FIN, ABORT.
- Write list, index 0..5: 0x01, addr[7:0], addr[15:8], addr[23:16], addr[31:24], 0x02. Each write: W_SETUP (`port_wdata` driven, `port_wr`=0), W_STROBE (`port_wr`=1), W_HOLD (`port_wr`=0). `port_wdata` stays stable from W_SETUP through W_HOLD and keeps its value until the next W_SETUP. This stability is mandatory because the port samples din every cycle while in its address states.
- After index 5 (0x02) or a next-byte write (0x04): SETTLE for SETTLE_CYC cycles, `port_addr`=0.
- POLL: `port_addr`=0 and `port_wr`=0. Sample `port_rdata[2:0]` each cycle. Bit1=1 goes to ABORT with code 01; this check has priority. Otherwise bit0=1 goes to READ. Otherwise increment the timeout counter; on all-ones, go to ABORT with code 10. The timeout counter clears on entry to SETTLE.
- READ: one cycle, `port_addr`=1; capture `port_rdata` into `out_data`; go to PUSH.
- PUSH: `out_valid`=1 and `out_data` stable until `out_ready`=1. On handshake, increment the byte counter. If the count reaches BLOCK_BYTES, go to FIN; otherwise write 0x04 (W_SETUP..W_HOLD), then SETTLE.
- FIN: `done`=1, then IDLE. ABORT: `error`=1, then IDLE; the partial block is not flushed.
- `port_en`=1 in every state except IDLE. `port_addr`=0 except in READ.
- `start` while `busy`=1 is ignored. `start` in the same cycle as `done`/`error` is ignored; it is accepted only in IDLE.
- Byte counter is 10 bits; compare against BLOCK_BYTES−1 at handshake to set `out_last`. No wrap: the count never exceeds BLOCK_BYTES.
- Reset mid-operation returns to IDLE immediately with outputs cleared. The port must share this reset, or be in its idle or wait state, before the next `start`. The 0x01 first write restarts address load from either state.

## Timing
- Accepted `start` at edge N: `busy`=1 and W_SETUP of 0x01 in cycle N+1. The 0x01 strobe occurs in cycle N+2.
- Six writes take 18 cycles. The first POLL is in cycle N+19+SETTLE_CYC.
- Ready seen in POLL at cycle P: READ in cycle P+1, `out_valid` rises at P+2.
- Handshake at cycle H (not last): 0x04 strobe at H+2, POLL from H+4+SETTLE_CYC.
- Last handshake at H: `done` at H+1, `busy` falls at H+2.
- Minimum per-byte period: 3+SETTLE_CYC+1+1+1 cycles with immediate ready.

## Test plan
- Nominal read: addr=0x12345678; port model shows ready 5 cycles into each poll. Required: 0x01,0x78,0x56,0x34,0x12,0x02 strobed in order. Then 512 bytes match the model pattern, `out_last` on byte 511, one `done`, 511 writes of 0x04.
- Backpressure: hold `out_ready` low for 20 cycles on byte 3. Required: `out_data` and `out_valid` stable, no 0x04 strobe until handshake.
- Card error: model sets status=010 at byte 100. Required: `error` pulse, `err_code`=01, no further strobes, `busy` low next cycle.
- Timeout: TO_W=6, status stuck at 100 (busy). Required: ABORT after 63 poll cycles, `err_code`=10.
- Reset mid-block: assert `reset` low at byte 40 for 1 cycle. Required: all outputs 0 asynchronously. A new `start` with addr=0x1 fetches a clean block.
- Spurious start: pulse `start` while `busy`=1 and in the `done` cycle. Required: no effect, exactly one block transferred.

Source files
------------

// File: rtl/sdcm_block_reader.sv
`timescale 1ns/1ps
`default_nettype none
// sdcm_block_reader: drives the SD-card port register bus to fetch one block
// and streams it out as a valid/ready byte stream.
module sdcm_block_reader #(
  parameter int BLOCK_BYTES = 512,
  parameter int SETTLE_CYC  = 4,
  parameter int TO_W        = 24
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] block_addr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_code_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_last_o,
  output logic        port_en_o,
  output logic        port_addr_o,
  output logic        port_wr_o,
  output logic [7:0]  port_wdata_o,
  input  logic [7:0]  port_rdata_i
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] W_SETUP  = 4'd1;
  localparam logic [3:0] W_STROBE = 4'd2;
  localparam logic [3:0] W_HOLD   = 4'd3;
  localparam logic [3:0] SETTLE   = 4'd4;
  localparam logic [3:0] POLL     = 4'd5;
  localparam logic [3:0] READ     = 4'd6;
  localparam logic [3:0] PUSH     = 4'd7;
  localparam logic [3:0] FIN      = 4'd8;
  localparam logic [3:0] ABORT    = 4'd9;

  localparam int         CNT_W     = 10;
  localparam int         SET_W     = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE  = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [SET_W-1:0] SETTLE_LD  = SET_W'(SETTLE_CYC - 1);

  logic [3:0]       state_q,  state_d;
  logic [2:0]       widx_q,   widx_d;
  logic [31:0]      addr_q,   addr_d;
  logic [7:0]       wdata_q,  wdata_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [TO_W-1:0]  to_q,     to_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [7:0]       data_q,   data_d;
  logic [1:0]       err_q,    err_d;

  logic [2:0] widx_nx;
  logic [7:0] wbyte_nx;

  assign widx_nx = widx_q + 3'd1;

  // Address-load write list: 0x01 is loaded on start, entries 1..4 are the
  // address bytes LSB first, entry 5 is the read-block command.
  always_comb begin
    case (widx_nx)
      3'd1:    wbyte_nx = addr_q[7:0];
      3'd2:    wbyte_nx = addr_q[15:8];
      3'd3:    wbyte_nx = addr_q[23:16];
      3'd4:    wbyte_nx = addr_q[31:24];
      default: wbyte_nx = 8'h02;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    settle_d = settle_q;
    to_d     = to_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = W_SETUP;
          addr_d  = block_addr_i;
          widx_d  = 3'd0;
          wdata_d = 8'h01;
          cnt_d   = '0;
          err_d   = 2'b00;
        end
      end
      W_SETUP:  state_d = W_STROBE;
      W_STROBE: state_d = W_HOLD;
      W_HOLD: begin
        if (widx_q == 3'd5) begin
          state_d  = SETTLE;
          settle_d = SETTLE_LD;
          to_d     = '0;
        end else begin
          state_d = W_SETUP;
          widx_d  = widx_nx;
          wdata_d = wbyte_nx;
        end
      end
      SETTLE: begin
        if (settle_q == '0) state_d = POLL;
        else                settle_d = settle_q - 1'b1;
      end
      POLL: begin
        if (port_rdata_i[1]) begin
          state_d = ABORT;
          err_d   = 2'b01;
        end else if (port_rdata_i[0]) begin
          state_d = READ;
        end else begin
          to_d = to_q + 1'b1;
          if (&to_d) begin
            state_d = ABORT;
            err_d   = 2'b10;
          end
        end
      end
      READ: begin
        data_d  = port_rdata_i;
        state_d = PUSH;
      end
      PUSH: begin
        if (out_ready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BYTE) begin
            state_d = FIN;
          end else begin
            // Next-byte command reuses the final write slot so W_HOLD exits to SETTLE.
            state_d = W_SETUP;
            widx_d  = 3'd5;
            wdata_d = 8'h04;
          end
        end
      end
      FIN:     state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      widx_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      settle_q <= '0;
      to_q     <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      settle_q <= settle_d;
      to_q     <= to_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign port_en_o    = (state_q != IDLE);
  assign done_o       = (state_q == FIN);
  assign error_o      = (state_q == ABORT);
  assign port_wr_o    = (state_q == W_STROBE);
  assign port_addr_o  = (state_q == READ);
  assign out_valid_o  = (state_q == PUSH);
  assign out_last_o   = (state_q == PUSH) && (cnt_q == LAST_BYTE);
  assign out_data_o   = data_q;
  assign port_wdata_o = wdata_q;
  assign err_code_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sdcm_block_reader.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for sdcm_block_reader with a behavioural SD-card port model.
module tb_sdcm_block_reader;

  localparam int BLOCK = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] block_addr;
  logic        busy, done, error, out_valid, out_ready, out_last;
  logic [1:0]  err_code;
  logic [7:0]  out_data;
  logic        port_en, port_addr, port_wr;
  logic [7:0]  port_wdata, port_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sdcm_block_reader #(.BLOCK_BYTES(BLOCK), .SETTLE_CYC(4), .TO_W(6)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .block_addr_i(block_addr),
    .busy_o(busy), .done_o(done), .error_o(error), .err_code_o(err_code),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_last_o(out_last), .port_en_o(port_en), .port_addr_o(port_addr),
    .port_wr_o(port_wr), .port_wdata_o(port_wdata), .port_rdata_i(port_rdata)
  );

  function automatic logic [7:0] pat(input logic [31:0] a, input int i);
    logic [7:0] s;
    s = a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
    return s + 8'(i * 37) + 8'(i >>> 8);
  endfunction

  // Port model: address load after 0x01, block/next-byte commands reset the
  // ready delay; status reads ready 5 cycles into each poll.
  int          m_err_at = -1;
  logic        m_stuck  = 1'b0;
  logic        m_load;
  logic [1:0]  m_acnt;
  logic [31:0] m_addr;
  int          m_idx, m_since;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load <= 1'b0; m_acnt <= 2'd0; m_addr <= '0; m_idx <= 0; m_since <= 0;
    end else begin
      if (m_since < 1000) m_since <= m_since + 1;
      if (port_en && port_wr && !port_addr) begin
        if (m_load) begin
          m_addr[8*m_acnt +: 8] <= port_wdata;
          m_acnt <= m_acnt + 2'd1;
          if (m_acnt == 2'd3) m_load <= 1'b0;
        end else if (port_wdata == 8'h01) begin
          m_load <= 1'b1; m_acnt <= 2'd0;
        end else if (port_wdata == 8'h02) begin
          m_idx <= 0; m_since <= 0;
        end else if (port_wdata == 8'h04) begin
          m_idx <= m_idx + 1; m_since <= 0;
        end
      end
    end
  end

  always_comb begin
    if (port_addr)             port_rdata = pat(m_addr, m_idx);
    else if (m_stuck)          port_rdata = 8'h04;
    else if (m_idx == m_err_at) port_rdata = 8'h02;
    else if (m_since >= 9)     port_rdata = 8'h01;
    else                       port_rdata = 8'h04;
  end

  int         n_strobe = 0, n_01 = 0, n_04 = 0, n_done = 0;
  logic [7:0] slog[$];

  always @(posedge clk) begin
    if (port_wr) begin
      n_strobe <= n_strobe + 1;
      slog.push_back(port_wdata);
      if (port_wdata == 8'h01) n_01 <= n_01 + 1;
      if (port_wdata == 8'h04) n_04 <= n_04 + 1;
    end
    if (done) n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_block(input logic [31:0] a);
    block_addr = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Receive n bytes; hold off ready for 20 cycles on byte bp, pulse start on byte spur.
  task automatic recv(input int n, input logic [31:0] a, input int bp, input int spur);
    int t;
    int s;
    logic [7:0] held;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!out_valid && t < 400) begin
        @(negedge clk);
        t++;
      end
      chk("byte_wait", {31'b0, out_valid}, 32'd1);
      if (!out_valid) return;
      chk("byte_data", {24'b0, out_data}, {24'b0, pat(a, i)});
      chk("byte_last", {31'b0, out_last}, {31'b0, (i == BLOCK - 1)});
      if (i == spur) begin
        start = 1'b1;
        block_addr = 32'hFFFF_FFFF;
      end
      if (i == bp) begin
        out_ready = 1'b0;
        held = out_data;
        s = n_strobe;
        repeat (20) begin
          @(negedge clk);
          start = 1'b0;
          chk("bp_valid", {31'b0, out_valid}, 32'd1);
          chk("bp_data", {24'b0, out_data}, {24'b0, held});
          chk("bp_strobes", n_strobe, s);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  int base, s01, s04, sdone, sstr, k;

  initial begin
    rst_n = 1'b0; start = 1'b0; block_addr = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_port_en", {31'b0, port_en}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_err_code", {30'b0, err_code}, 32'd0);
    chk("rst_wdata", {24'b0, port_wdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal block with backpressure on byte 3 and spurious starts
    base = slog.size(); s01 = n_01; s04 = n_04; sdone = n_done;
    start_block(32'h1234_5678);
    chk("st_busy", {31'b0, busy}, 32'd1);
    chk("st_wdata", {24'b0, port_wdata}, 32'h01);
    chk("st_wr0", {31'b0, port_wr}, 32'd0);
    @(negedge clk);
    chk("st_wr1", {31'b0, port_wr}, 32'd1);
    recv(BLOCK, 32'h1234_5678, 3, 5);
    chk("nom_done", {31'b0, done}, 32'd1);
    start = 1'b1; block_addr = 32'h0;
    @(negedge clk);
    start = 1'b0;
    chk("nom_busy_fall", {31'b0, busy}, 32'd0);
    chk("nom_done_pulse", {31'b0, done}, 32'd0);
    repeat (30) @(negedge clk);
    chk("spur_idle", {31'b0, busy}, 32'd0);
    chk("seq0", {24'b0, slog[base+0]}, 32'h01);
    chk("seq1", {24'b0, slog[base+1]}, 32'h78);
    chk("seq2", {24'b0, slog[base+2]}, 32'h56);
    chk("seq3", {24'b0, slog[base+3]}, 32'h34);
    chk("seq4", {24'b0, slog[base+4]}, 32'h12);
    chk("seq5", {24'b0, slog[base+5]}, 32'h02);
    chk("nom_n01", n_01 - s01, 32'd1);
    chk("nom_n04", n_04 - s04, 32'd511);
    chk("nom_ndone", n_done - sdone, 32'd1);

    // Card error reported on byte 100
    m_err_at = 100;
    start_block(32'h0000_0100);
    recv(100, 32'h0000_0100, -1, -1);
    k = 0;
    while (!error && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("cerr_pulse", {31'b0, error}, 32'd1);
    chk("cerr_code", {30'b0, err_code}, 32'd1);
    sstr = n_strobe;
    @(negedge clk);
    chk("cerr_busy", {31'b0, busy}, 32'd0);
    chk("cerr_pulse_end", {31'b0, error}, 32'd0);
    chk("cerr_code_hold", {30'b0, err_code}, 32'd1);
    repeat (10) @(negedge clk);
    chk("cerr_no_strobe", n_strobe, sstr);
    m_err_at = -1;

    // Poll timeout: 18 write cycles + 4 settle + 63 polls, ABORT in cycle N+86
    m_stuck = 1'b1;
    start_block(32'h0000_0200);
    chk("to_code_clr", {30'b0, err_code}, 32'd0);
    k = 1;
    while (!error && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("to_pulse", {31'b0, error}, 32'd1);
    chk("to_cycle", k, 32'd86);
    chk("to_code", {30'b0, err_code}, 32'd2);
    m_stuck = 1'b0;
    @(negedge clk);

    // Reset mid-block, then a clean block
    start_block(32'hCAFE_0040);
    recv(40, 32'hCAFE_0040, -1, -1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", {31'b0, busy}, 32'd0);
    chk("mr_port_en", {31'b0, port_en}, 32'd0);
    chk("mr_wdata", {24'b0, port_wdata}, 32'd0);
    chk("mr_out_data", {24'b0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_block(32'h0000_0001);
    recv(BLOCK, 32'h0000_0001, -1, -1);
    chk("mr_done", {31'b0, done}, 32'd1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
